as1802_bus_adapter: RTL and testbench

AS1802_BUS_ADAPTER -- requirements
Module: as1802_bus_adapter

---
 rtl/as1802_bus_adapter.sv | 158 +++++++++++++++
 tb/tb_as1802_bus_adapter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/as1802_bus_adapter.sv
// rtl/as1802_bus_adapter.sv - 1802-style multiplexed CPU bus to handshaked memory adapter
// One memory access per CPU strobe, high-byte address latch, synchronized EF flag inputs.
module as1802_bus_adapter #(
  parameter int              MIN_WAIT = 0,
  parameter int              N_EF     = 4,
  parameter logic [N_EF-1:0] EF_EDGE  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      cpu_addr,
  input  logic            cpu_tpa,
  input  logic            cpu_mrd_n,
  input  logic            cpu_mwr_n,
  input  logic [1:0]      cpu_sc,
  input  logic [7:0]      cpu_dout,
  output logic [7:0]      cpu_din,
  output logic            cpu_stall,
  output logic [15:0]     mem_addr,
  output logic [7:0]      mem_wdata,
  input  logic [7:0]      mem_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic            mem_fetch,
  input  logic            mem_ready,
  input  logic [N_EF-1:0] ext_ef,
  input  logic [N_EF-1:0] ef_clr,
  output logic [N_EF-1:0] cpu_ef
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [3:0] WAIT_MAX  = 4'(MIN_WAIT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  hi_latch_q, hi_latch_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_fetch_q, mem_fetch_d;
  logic [7:0]  cpu_din_q, cpu_din_d;
  logic        strobe;

  assign strobe = ~cpu_mrd_n | ~cpu_mwr_n;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_fetch_d = mem_fetch_q;
    cpu_din_d   = cpu_din_q;
    // The latch follows TPA in every state; the in-flight address lives in mem_addr_q.
    hi_latch_d  = cpu_tpa ? cpu_addr : hi_latch_q;

    case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          mem_addr_d  = {hi_latch_q, cpu_addr};
          mem_we_d    = ~cpu_mwr_n & cpu_mrd_n;
          mem_wdata_d = cpu_dout;
          mem_fetch_d = (cpu_sc == 2'b00);
          mem_req_d   = 1'b1;
          wait_cnt_d  = 4'd0;
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (wait_cnt_q != WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end else if (mem_ready) begin
          if (!mem_we_q) begin
            cpu_din_d = mem_rdata;
          end
          mem_req_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!strobe) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hi_latch_q  <= 8'd0;
      wait_cnt_q  <= 4'd0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_fetch_q <= 1'b0;
      cpu_din_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      hi_latch_q  <= hi_latch_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_fetch_q <= mem_fetch_d;
      cpu_din_q   <= cpu_din_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_fetch = mem_fetch_q;
  assign cpu_din   = cpu_din_q;
  assign cpu_stall = ~rst & (((state_q == ST_IDLE) & strobe) | (state_q == ST_ACCESS));

  // EF path: two-flop synchronizer, then a history flop for rising-edge detection.
  logic [N_EF-1:0] ef_meta_q, ef_meta_d;
  logic [N_EF-1:0] ef_sync_q, ef_sync_d;
  logic [N_EF-1:0] ef_prev_q, ef_prev_d;
  logic [N_EF-1:0] ef_sticky_q, ef_sticky_d;
  logic [N_EF-1:0] ef_rise;

  always_comb begin
    ef_meta_d   = ext_ef;
    ef_sync_d   = ef_meta_q;
    ef_prev_d   = ef_sync_q;
    ef_rise     = ef_sync_q & ~ef_prev_q;
    // Set has priority over clear; level channels never hold sticky state.
    ef_sticky_d = (ef_rise | (ef_sticky_q & ~ef_clr)) & EF_EDGE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ef_meta_q   <= '0;
      ef_sync_q   <= '0;
      ef_prev_q   <= '0;
      ef_sticky_q <= '0;
    end else begin
      ef_meta_q   <= ef_meta_d;
      ef_sync_q   <= ef_sync_d;
      ef_prev_q   <= ef_prev_d;
      ef_sticky_q <= ef_sticky_d;
    end
  end

  assign cpu_ef = (EF_EDGE & ef_sticky_q) | (~EF_EDGE & ef_sync_q);

endmodule

// File: tb/tb_as1802_bus_adapter.sv
// tb/tb_as1802_bus_adapter.sv - directed self-checking bench for as1802_bus_adapter
// Instance a: MIN_WAIT=0, EF_EDGE=4'b0010; instance b: MIN_WAIT=3, level-mode flags.
module tb_as1802_bus_adapter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  a_addr, a_dout, a_din, a_mem_wdata, a_mem_rdata;
  logic        a_tpa, a_mrd_n, a_mwr_n, a_stall, a_mem_req, a_mem_we, a_mem_fetch, a_mem_ready;
  logic [1:0]  a_sc;
  logic [15:0] a_mem_addr;
  logic [3:0]  a_ext_ef, a_ef_clr, a_cpu_ef;

  logic [7:0]  b_addr, b_dout, b_din, b_mem_wdata, b_mem_rdata;
  logic        b_tpa, b_mrd_n, b_mwr_n, b_stall, b_mem_req, b_mem_we, b_mem_fetch, b_mem_ready;
  logic [1:0]  b_sc;
  logic [15:0] b_mem_addr;
  logic [3:0]  b_ext_ef, b_ef_clr, b_cpu_ef;

  as1802_bus_adapter #(.MIN_WAIT(0), .N_EF(4), .EF_EDGE(4'b0010)) dut_a (
    .clk(clk), .rst(rst), .cpu_addr(a_addr), .cpu_tpa(a_tpa), .cpu_mrd_n(a_mrd_n),
    .cpu_mwr_n(a_mwr_n), .cpu_sc(a_sc), .cpu_dout(a_dout), .cpu_din(a_din),
    .cpu_stall(a_stall), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .mem_req(a_mem_req), .mem_we(a_mem_we),
    .mem_fetch(a_mem_fetch), .mem_ready(a_mem_ready), .ext_ef(a_ext_ef),
    .ef_clr(a_ef_clr), .cpu_ef(a_cpu_ef)
  );

  as1802_bus_adapter #(.MIN_WAIT(3), .N_EF(4), .EF_EDGE(4'b0000)) dut_b (
    .clk(clk), .rst(rst), .cpu_addr(b_addr), .cpu_tpa(b_tpa), .cpu_mrd_n(b_mrd_n),
    .cpu_mwr_n(b_mwr_n), .cpu_sc(b_sc), .cpu_dout(b_dout), .cpu_din(b_din),
    .cpu_stall(b_stall), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_req(b_mem_req), .mem_we(b_mem_we),
    .mem_fetch(b_mem_fetch), .mem_ready(b_mem_ready), .ext_ef(b_ext_ef),
    .ef_clr(b_ef_clr), .cpu_ef(b_cpu_ef)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int          hi_cnt, pulses;
  logic        prev_req, we_seen, stall_ok;
  logic [15:0] addr_seen;
  logic [7:0]  wdata_seen;

  initial begin
    rst = 1'b1;
    a_addr = 0; a_tpa = 0; a_mrd_n = 1; a_mwr_n = 1; a_sc = 0; a_dout = 0;
    a_mem_rdata = 0; a_mem_ready = 0; a_ext_ef = 0; a_ef_clr = 0;
    b_addr = 0; b_tpa = 0; b_mrd_n = 1; b_mwr_n = 1; b_sc = 0; b_dout = 0;
    b_mem_rdata = 0; b_mem_ready = 0; b_ext_ef = 0; b_ef_clr = 0;

    // Reset state, stall gated while rst is high
    repeat (2) @(negedge clk);
    a_mrd_n = 1'b0;
    #1;
    check("rst_stall", 32'(a_stall), 0);
    check("rst_req", 32'(a_mem_req), 0);
    check("rst_addr", 32'(a_mem_addr), 0);
    check("rst_din", 32'(a_din), 0);
    check("rst_ef", 32'(a_cpu_ef), 0);
    a_mrd_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic read, MIN_WAIT=0
    a_tpa = 1; a_addr = 8'h12;
    @(negedge clk);
    a_tpa = 0; a_addr = 8'h34; a_mrd_n = 0; a_sc = 2'b00; a_mem_ready = 1; a_mem_rdata = 8'hA5;
    #1;
    check("rd_stall_idle", 32'(a_stall), 1);
    @(negedge clk);
    check("rd_addr", 32'(a_mem_addr), 'h1234);
    check("rd_req", 32'(a_mem_req), 1);
    check("rd_we", 32'(a_mem_we), 0);
    check("rd_fetch_sc00", 32'(a_mem_fetch), 1);
    check("rd_stall_access", 32'(a_stall), 1);
    @(negedge clk);
    check("rd_din", 32'(a_din), 'hA5);
    check("rd_req_drop", 32'(a_mem_req), 0);
    check("rd_stall_fall", 32'(a_stall), 0);
    repeat (3) @(negedge clk);
    check("rd_held_no_req", 32'(a_mem_req), 0);
    a_mrd_n = 1;
    @(negedge clk);

    // sc=01 read is not a fetch; TPA mid-access updates latch only
    a_sc = 2'b01; a_addr = 8'h40; a_mrd_n = 0; a_mem_ready = 0; a_mem_rdata = 8'h3C;
    @(negedge clk);
    check("sc01_fetch", 32'(a_mem_fetch), 0);
    check("sc01_addr", 32'(a_mem_addr), 'h1240);
    a_tpa = 1; a_addr = 8'h56;
    @(negedge clk);
    a_tpa = 0;
    check("tpa_addr_hold", 32'(a_mem_addr), 'h1240);
    check("wait_req_hold", 32'(a_mem_req), 1);
    check("wait_din_hold", 32'(a_din), 'hA5);
    a_mem_ready = 1;
    @(negedge clk);
    check("sc01_din", 32'(a_din), 'h3C);
    a_mrd_n = 1; a_mem_ready = 0;
    @(negedge clk);

    // Both strobes low -> read; held strobe gives one pulse only
    a_addr = 8'h78; a_dout = 8'hFF; a_mrd_n = 0; a_mwr_n = 0; a_mem_rdata = 8'h99;
    a_mem_ready = 1; a_sc = 2'b00;
    hi_cnt = 0; pulses = 0; prev_req = 0; we_seen = 1; addr_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (a_mem_req) begin
        hi_cnt++; we_seen = a_mem_we; addr_seen = a_mem_addr;
        if (!prev_req) pulses++;
      end
      prev_req = a_mem_req;
    end
    check("both_pulses", 32'(pulses), 1);
    check("both_req_cycles", 32'(hi_cnt), 1);
    check("both_we", 32'(we_seen), 0);
    check("both_addr_new_latch", 32'(addr_seen), 'h5678);
    check("both_din", 32'(a_din), 'h99);
    a_mrd_n = 1; a_mwr_n = 1;
    @(negedge clk);

    // Reset mid-access
    a_mem_ready = 0; a_addr = 8'h10; a_mrd_n = 0; a_mem_rdata = 8'h77;
    @(negedge clk);
    check("rstmid_req_pre", 32'(a_mem_req), 1);
    rst = 1;
    @(negedge clk);
    check("rstmid_req", 32'(a_mem_req), 0);
    check("rstmid_din", 32'(a_din), 0);
    check("rstmid_stall", 32'(a_stall), 0);
    a_mrd_n = 1;
    @(negedge clk);
    rst = 0; a_mem_ready = 1;
    repeat (2) @(negedge clk);
    check("rstmid_idle_req", 32'(a_mem_req), 0);
    check("rstmid_idle_din", 32'(a_din), 0);
    a_addr = 8'h21; a_mrd_n = 0; a_mem_rdata = 8'h42;
    @(negedge clk);
    check("rstmid_fresh_addr", 32'(a_mem_addr), 'h0021);
    @(negedge clk);
    check("rstmid_fresh_din", 32'(a_din), 'h42);
    a_mrd_n = 1; a_mem_ready = 0;
    @(negedge clk);

    // Level-mode channel 0: 2-cycle latency, ef_clr ignored
    a_ext_ef = 4'b0001;
    @(negedge clk);
    check("lvl_lat1", 32'(a_cpu_ef[0]), 0);
    @(negedge clk);
    check("lvl_lat2", 32'(a_cpu_ef[0]), 1);
    a_ef_clr = 4'b0001;
    @(negedge clk);
    a_ef_clr = 0;
    check("lvl_clr_ignored", 32'(a_cpu_ef[0]), 1);
    a_ext_ef = 0;
    repeat (3) @(negedge clk);
    check("lvl_fall", 32'(a_cpu_ef), 0);

    // Edge-mode channel 1: sticky until cleared
    a_ext_ef = 4'b0010;
    @(negedge clk);
    a_ext_ef = 0;
    @(negedge clk);
    check("edge_not_level", 32'(a_cpu_ef[1]), 0);
    @(negedge clk);
    check("edge_set", 32'(a_cpu_ef[1]), 1);
    repeat (5) @(negedge clk);
    check("edge_sticky", 32'(a_cpu_ef), 'b0010);
    a_ef_clr = 4'b0010;
    @(negedge clk);
    a_ef_clr = 0;
    check("edge_clr", 32'(a_cpu_ef[1]), 0);

    // Edge coincident with clear: set wins
    a_ext_ef = 4'b0010;
    @(negedge clk);
    a_ext_ef = 0;
    @(negedge clk);
    check("edge_pre_coinc", 32'(a_cpu_ef[1]), 0);
    a_ef_clr = 4'b0010;
    @(negedge clk);
    a_ef_clr = 0;
    check("edge_set_wins", 32'(a_cpu_ef[1]), 1);

    // MIN_WAIT=3 write with mem_ready tied high
    b_tpa = 1; b_addr = 8'hAB;
    @(negedge clk);
    b_tpa = 0; b_addr = 8'hCD; b_dout = 8'h5A; b_mwr_n = 0; b_mem_ready = 1; b_sc = 2'b01;
    hi_cnt = 0; pulses = 0; prev_req = 0; we_seen = 0; wdata_seen = 0; addr_seen = 0;
    stall_ok = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b_mem_req) begin
        hi_cnt++; we_seen = b_mem_we; wdata_seen = b_mem_wdata; addr_seen = b_mem_addr;
        if (!b_stall) stall_ok = 0;
        if (!prev_req) pulses++;
      end
      prev_req = b_mem_req;
    end
    check("wr_req_cycles", 32'(hi_cnt), 4);
    check("wr_pulses", 32'(pulses), 1);
    check("wr_we", 32'(we_seen), 1);
    check("wr_wdata", 32'(wdata_seen), 'h5A);
    check("wr_addr", 32'(addr_seen), 'hABCD);
    check("wr_stall", 32'(stall_ok), 1);
    check("wr_din_unchanged", 32'(b_din), 0);
    b_mwr_n = 1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
